// File: rtl/fir_filter_pkg.sv
// Shared definitions for the FIR filter output-control slice.
// Contents: default accumulator/output widths, phase tags, FSM state
// encoding and output saturation bounds.
package fir_filter_pkg;

  localparam int ACC_W_DEF = 48;
  localparam int OUT_W_DEF = 24;

  // Phase tags carried alongside each accumulator result.
  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;

  // Output-control FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Largest representable signed sample of width w.
  function automatic longint sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest representable signed sample of width w.
  function automatic longint sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_filter_out_fifo.sv
// Synchronous first-word-fall-through FIFO for post-processed samples.
// Ports:
//   clk, rst_n          clock, async active-low reset (pointers/count only)
//   push, push_data     write request and data
//   pop                 read request (ignored when empty)
//   pop_data            head entry, valid whenever !empty
//   full, empty, count  occupancy status
// A push while full is accepted only when a pop happens in the same cycle.
module fir_filter_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(DEPTH));
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_filter_output_control.sv
// Output side of the FIR filter: accepts per-phase accumulator results,
// checks their phase rotation, rounds/shifts/saturates them to the output
// width, buffers them and serialises them onto one valid/ready stream,
// framed by tc_write.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   tc_write              frame start (only honoured in IDLE)
//   acc_valid/phase/data  accumulator result input
//   out_data/valid/ready  output stream, out_last marks final beat
//   busy                  FSM not idle
//   ovf_err, seq_err      sticky drop / phase-order flags, cleared at frame start
module fir_filter_output_control
  import fir_filter_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int SHIFT      = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tc_write,
  input  logic                    acc_valid,
  input  logic [1:0]              acc_phase,
  input  logic signed [ACC_W-1:0] acc_data,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    ovf_err,
  output logic                    seq_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FL_W  = $clog2(FRAME_LEN + 1);

  localparam logic signed [ACC_W:0] RND      = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_HI_W = (ACC_W+1)'(sat_hi(OUT_W));
  localparam logic signed [ACC_W:0] SAT_LO_W = (ACC_W+1)'(sat_lo(OUT_W));

  // Add half an LSB in one extra bit of headroom, then floor-shift:
  // rounds half toward +inf.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + RND;
    return s >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] x);
    if (x > SAT_HI_W)      return SAT_HI_W[OUT_W-1:0];
    else if (x < SAT_LO_W) return SAT_LO_W[OUT_W-1:0];
    else                   return x[OUT_W-1:0];
  endfunction

  logic [1:0]              r_state;
  logic [FL_W-1:0]         r_acc_cnt;
  logic [FL_W-1:0]         r_beat_cnt;
  logic [1:0]              r_exp_ph;
  logic                    r_ovf_err;
  logic                    r_seq_err;
  logic                    r_vld_p1;
  logic signed [OUT_W-1:0] r_data_p1;

  logic                    w_take;
  logic                    w_bad_ph;
  logic                    w_no_room;
  logic                    w_accept;
  logic                    w_pop;
  logic                    w_last_beat;
  logic [1:0]              w_exp_next;
  logic                    w_full;
  logic                    w_empty;
  logic [CNT_W-1:0]        w_count;
  logic [OUT_W-1:0]        w_head;

  assign w_take   = (r_state == ST_RUN) && acc_valid;
  assign w_bad_ph = (acc_phase == 2'd3);
  // Buffer space counts the in-flight stage-1 sample; a same-cycle pop is
  // deliberately not credited. The FIFO can never be full while stage 1
  // holds a sample, so this equals count + vld == depth.
  assign w_no_room  = w_full || ((w_count == CNT_W'(FIFO_DEPTH - 1)) && r_vld_p1);
  assign w_accept   = w_take && !w_bad_ph && !w_no_room;
  assign w_exp_next = (acc_phase == PH2) ? PH0 : acc_phase + 2'd1;

  assign w_pop       = !w_empty && out_ready;
  assign w_last_beat = (r_beat_cnt == FL_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc_cnt  <= '0;
      r_beat_cnt <= '0;
      r_exp_ph   <= PH0;
      r_ovf_err  <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (tc_write) begin
            r_state    <= ST_RUN;
            r_acc_cnt  <= '0;
            r_beat_cnt <= '0;
            r_exp_ph   <= PH0;
            r_ovf_err  <= 1'b0;
            r_seq_err  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_take && w_bad_ph) r_seq_err <= 1'b1;
          if (w_take && !w_bad_ph && w_no_room) r_ovf_err <= 1'b1;
          if (w_accept) begin
            if (acc_phase != r_exp_ph) r_seq_err <= 1'b1;
            r_exp_ph  <= w_exp_next;
            r_acc_cnt <= r_acc_cnt + FL_W'(1);
            if (r_acc_cnt == FL_W'(FRAME_LEN - 1)) r_state <= ST_DRAIN;
          end
          if (w_pop) r_beat_cnt <= r_beat_cnt + FL_W'(1);
        end
        ST_DRAIN: begin
          if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + FL_W'(1);
            if (w_last_beat) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage 0 -> stage 1: round, shift, saturate ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= w_accept;
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_data_p1 <= saturate(round_shift(acc_data));
  end

  // ---- stage 1 -> buffer: unconditional push, space was reserved at accept ----
  fir_filter_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_vld_p1),
    .push_data (r_data_p1),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : $signed(w_head);
  assign out_last  = !w_empty && w_last_beat;
  assign busy      = (r_state != ST_IDLE);
  assign ovf_err   = r_ovf_err;
  assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_fir_filter_output_control.sv
module tb_fir_filter_output_control;

  localparam int ACC_W = 48;
  localparam int OUT_W = 24;
  localparam int SHIFT = 16;
  localparam int FL    = 6;
  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    tc_write = 1'b0;
  logic                    acc_valid = 1'b0;
  logic [1:0]              acc_phase = 2'd0;
  logic signed [ACC_W-1:0] acc_data = '0;
  logic                    out_ready = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid, out_last, busy, ovf_err, seq_err;

  always #5 clk = ~clk;

  fir_filter_output_control #(
    .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tc_write(tc_write), .acc_valid(acc_valid),
    .acc_phase(acc_phase), .acc_data(acc_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .ovf_err(ovf_err), .seq_err(seq_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: samples in flight (stage 1 + buffer) as a queue of
  // {expected output, first cycle it may appear at the output}.
  typedef struct { longint val; int vis; } ent_t;
  ent_t   q[$];
  int     m_state;   // 0 idle, 1 run, 2 drain
  int     m_acc, m_beats, m_exp, cyc;
  bit     m_ovf, m_seq;
  longint got[$];

  typedef struct { longint acc; longint exp; } vec_t;
  vec_t tbl[FL];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Round half toward +inf after dividing by 2^SHIFT, then clamp.
  function automatic longint ref_out(input longint v);
    longint t, r;
    t = v + (64'sd1 <<< (SHIFT - 1));
    if (t >= 0) r = t / (64'sd1 <<< SHIFT);
    else        r = -((-t + (64'sd1 <<< SHIFT) - 1) / (64'sd1 <<< SHIFT));
    if (r > 8388607)  r = 8388607;
    if (r < -8388608) r = -8388608;
    return r;
  endfunction

  task automatic m_reset();
    q.delete();
    m_state = 0; m_acc = 0; m_beats = 0; m_exp = 0; m_ovf = 0; m_seq = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model,
  // advance the model by the rules for the coming edge, then clock.
  task automatic step(input bit tcw, input bit av, input logic [1:0] ph,
                      input longint d, input bit rdy);
    bit v, pop, lastb;
    int st0, occ;
    tc_write = tcw; acc_valid = av; acc_phase = ph; acc_data = d[ACC_W-1:0]; out_ready = rdy;
    #1;
    v     = (q.size() > 0) && (q[0].vis <= cyc);
    lastb = v && (m_beats == FL - 1);
    chk("out_valid", out_valid, v);
    chk("out_last", out_last, lastb);
    chk("busy", busy, m_state != 0);
    chk("ovf_err", ovf_err, m_ovf);
    chk("seq_err", seq_err, m_seq);
    if (v) chk("out_data", out_data, q[0].val);
    st0 = m_state;
    occ = q.size();
    pop = v && rdy;
    if (pop) begin
      got.push_back(longint'(out_data));
      void'(q.pop_front());
      m_beats++;
    end
    if (st0 == 0 && tcw) begin
      m_state = 1; m_acc = 0; m_beats = 0; m_exp = 0; m_ovf = 0; m_seq = 0;
    end else if (st0 == 1 && av) begin
      if (ph == 2'd3) m_seq = 1;
      else if (occ == DEPTH) m_ovf = 1;
      else begin
        if (int'(ph) != m_exp) m_seq = 1;
        m_exp = (int'(ph) + 1) % 3;
        q.push_back('{ref_out(d), cyc + 2});
        m_acc++;
        if (m_acc == FL) m_state = 2;
      end
    end else if (st0 == 2 && pop && lastb) begin
      m_state = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && m_state != 0; i++) step(1'b0, 1'b0, 2'd0, 0, 1'b1);
    chk("frame_end_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint d;
    logic [1:0] ph;

    tbl[0] = '{64'sh18000, 2};
    tbl[1] = '{-64'sh18000, -1};
    tbl[2] = '{64'sh17FFF, 1};
    tbl[3] = '{64'sd1 <<< 40, 8388607};
    tbl[4] = '{-(64'sd1 <<< 40), -8388608};
    tbl[5] = '{64'sd6 <<< 16, 6};

    // ---- reset with acc_valid high ----
    #1; rst_n = 1'b0; acc_valid = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_seq", seq_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset(); cyc = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i % 3), 64'sd5 <<< 16, 1'b1);

    // ---- rounding / saturation vectors ----
    got.delete();
    step(1'b1, 1'b0, 2'd0, 0, 1'b1);
    for (int i = 0; i < FL; i++) step(1'b0, 1'b1, 2'(i % 3), tbl[i].acc, 1'b1);
    drain(20);
    chk("tbl_count", got.size(), FL);
    for (int i = 0; i < FL && i < got.size(); i++) chk($sformatf("tbl_%0d", i), got[i], tbl[i].exp);

    // ---- full frame, in-order phases ----
    got.delete();
    step(1'b1, 1'b0, 2'd0, 0, 1'b1);
    for (int n = 1; n <= FL; n++) step(1'b0, 1'b1, 2'((n - 1) % 3), longint'(n) <<< 16, 1'b1);
    drain(20);
    chk("frame_count", got.size(), FL);
    for (int i = 0; i < FL && i < got.size(); i++) chk($sformatf("frame_%0d", i), got[i], i + 1);
    chk("frame_seq", seq_err, 0);
    chk("frame_ovf", ovf_err, 0);

    // ---- backpressure: buffer fills, later samples dropped ----
    got.delete();
    step(1'b1, 1'b0, 2'd0, 0, 1'b0);
    for (int n = 1; n <= FL; n++) step(1'b0, 1'b1, 2'((n - 1) % 3), longint'(20 + n) <<< 16, 1'b0);
    chk("bp_ovf", ovf_err, 1);
    chk("bp_busy_run", busy, 1);
    step(1'b0, 1'b0, 2'd0, 0, 1'b0);
    chk("bp_stall_data", out_data, 21);
    step(1'b0, 1'b0, 2'd0, 0, 1'b0);
    chk("bp_stall_data2", out_data, 21);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2'd0, 0, 1'b1);
    chk("bp_beats", got.size(), DEPTH);
    chk("bp_still_busy", busy, 1);
    step(1'b0, 1'b1, 2'd1, 64'sd25 <<< 16, 1'b1);
    step(1'b0, 1'b1, 2'd2, 64'sd26 <<< 16, 1'b1);
    drain(20);
    chk("bp_total", got.size(), FL);
    for (int i = 0; i < FL && i < got.size(); i++) chk($sformatf("bp_%0d", i), got[i], 21 + i);

    // ---- phase order violation 0,2,0 then in order ----
    got.delete();
    step(1'b1, 1'b0, 2'd0, 0, 1'b1);
    step(1'b0, 1'b1, 2'd0, 64'sd7 <<< 16, 1'b1);
    chk("seq_after_first", seq_err, 0);
    step(1'b0, 1'b1, 2'd2, 64'sd8 <<< 16, 1'b1);
    chk("seq_after_second", seq_err, 1);
    step(1'b0, 1'b1, 2'd0, 64'sd9 <<< 16, 1'b1);
    step(1'b0, 1'b1, 2'd1, 64'sd10 <<< 16, 1'b1);
    step(1'b0, 1'b1, 2'd2, 64'sd11 <<< 16, 1'b1);
    step(1'b0, 1'b1, 2'd0, 64'sd12 <<< 16, 1'b1);
    drain(20);
    chk("seq_count", got.size(), FL);
    for (int i = 0; i < FL && i < got.size(); i++) chk($sformatf("seq_%0d", i), got[i], 7 + i);

    // ---- reset in the middle of a frame ----
    step(1'b1, 1'b0, 2'd0, 0, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 2'(n), longint'(30 + n) <<< 16, 1'b0);
    step(1'b0, 1'b0, 2'd0, 0, 1'b0);
    chk("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    got.delete();
    step(1'b1, 1'b0, 2'd0, 0, 1'b1);
    for (int n = 0; n < FL; n++) step(1'b0, 1'b1, 2'(n % 3), longint'(40 + n) <<< 16, 1'b1);
    drain(20);
    chk("mid_new_count", got.size(), FL);
    for (int i = 0; i < FL && i < got.size(); i++) chk($sformatf("mid_%0d", i), got[i], 40 + i);

    // ---- randomized frames against the model ----
    for (int f = 0; f < 10; f++) begin
      step(1'b1, 1'b0, 2'd0, 0, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 300 && m_state != 0; c++) begin
        case ($urandom_range(0, 9))
          0:       ph = 2'd3;
          1:       ph = 2'($urandom_range(0, 2));
          default: ph = 2'(m_exp);
        endcase
        if ($urandom_range(0, 3) == 0) begin
          d = {32'($urandom), 32'($urandom)};
          d = (d <<< 16) >>> 16;
        end else begin
          d = longint'($signed(32'($urandom))) >>> $urandom_range(0, 12);
        end
        step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0), ph, d,
             1'($urandom_range(0, 3) != 0));
      end
      chk($sformatf("rand_frame_%0d_done", f), busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
